butterfly_in: RTL and testbench
===============================

Name: butterfly_in

Overview:
- Read-side crossbar for the NTT datapath. It is the counterpart of the butterfly-output write network.
- Takes the four memory-bank read words (q0..q3) and routes them to the two butterfly units' upper/lower inputs.
- The per-port bank selects are issued in the same cycle as the read address. They are delayed internally to line up with bank read latency, then the routed operands are registered (the single bf_in DFF stage).
- Also tracks beat validity and per-stage beat count, and flags select collisions.

Parameters:
- data_width, 12, coefficient width.
- RD_LAT, 1, bank read latency in cycles, from rd_en/address to q valid (legal range 1..4).
- BF_CNT, 64, butterfly-pair beats per NTT stage (power of two, >=2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse at the beginning of a stage. Clears the beat counter, the error flag and in-flight beats.
- rd_en  input  1  read issued this cycle; accompanies sel_b_*.
- sel_b_0  input  2  bank index feeding bf_0_upper.
- sel_b_1  input  2  bank index feeding bf_0_lower.
- sel_b_2  input  2  bank index feeding bf_1_upper.
- sel_b_3  input  2  bank index feeding bf_1_lower.
- q0,q1,q2,q3  input  data_width each  bank 0..3 read data.
- bf_0_upper,bf_0_lower,bf_1_upper,bf_1_lower  output  data_width each  registered butterfly operands.
- bf_valid  output  1  operands valid this cycle.
- bf_last  output  1  final beat of the stage; asserted only with bf_valid.
- sel_err  output  1  sticky collision flag.

Behaviour:
- Reset (rst low, async):
  - all four operand outputs = 0; bf_valid = 0; bf_last = 0; sel_err = 0.
  - beat counter = 0; delay lines cleared.
- Select/valid delay line:
  - {rd_en, sel_b_0..3} enter an RD_LAT-deep shift register each cycle.
  - The tap aligns with q0..q3 for that read.
- Routing (combinational at the tap):
  - operand = q[sel], with code 00→q0, 01→q1, 10→q2, 11→q3.
  - Each port is independent.
- Output register:
  - If the tapped rd_en is 1, the four routed words load and bf_valid = 1 next cycle.
  - Otherwise operands hold their previous values and bf_valid = 0.
- Latency: rd_en at cycle t → bf_valid at t+RD_LAT+1, carrying q sampled at t+RD_LAT.
- Throughput: one beat per cycle; back-to-back rd_en gives back-to-back bf_valid, with no bubbles.
- Beat counter:
  - Width $clog2(BF_CNT); increments on each loaded beat.
  - bf_last = 1 with the beat loaded while count == BF_CNT-1.
  - The counter then wraps to 0. Beats beyond BF_CNT without start simply begin a new count.
- Collision check:
  - Performed at the tap for valid beats only.
  - If any two of the four tapped selects are equal, sel_err sets on the same edge the beat loads.
  - The beat is still loaded as routed. sel_err stays 1 until start or reset.
- start:
  - Synchronous; highest priority.
  - Clears the counter, sel_err and every rd_en bit in the delay line, so in-flight reads are discarded and produce no bf_valid.
  - Forces bf_valid/bf_last to 0 next cycle.
  - rd_en in the same cycle as start is accepted as the first beat of the new stage.
- Selects with rd_en = 0 are don't-care and never set sel_err.
- A mode (radix-2/radix-4) has no effect here: radix-4 groups use all four ports, radix-2 uses the same mapping.

Decomposition:
- Shared package ntt_pkg holds:
  - bank-index typedef (2 bits);
  - BANK0..BANK3 constants;
  - data_width default.
- One natural sub-module, sel_delay: parameterised depth/width shift register with async active-low clear and synchronous flush. It is instantiated once for {rd_en, 8 select bits}.
- Mux, collision compare and counter stay in butterfly_in.

Test Plan:
- Reset check: hold rst low with random inputs → all outputs 0. Release, then rd_en=1, sels 0,1,2,3, q=10,20,30,40 at the read-data cycle (RD_LAT=1) → two cycles after rd_en, bf_valid=1 and bf_0_upper=10, bf_0_lower=20, bf_1_upper=30, bf_1_lower=40.
- Permuted routing: sels 3,2,1,0 with q=0x111,0x222,0x333,0xABC → operands 0xABC, 0x333, 0x222, 0x111. Then rd_en=0 for one cycle → operands hold and bf_valid=0.
- Stage count: start, then 64 consecutive rd_en → 64 consecutive bf_valid with bf_last only on beat 64. A 65th rd_en → bf_last=0 on it.
- Collision: rd_en with sels 1,1,2,3 → sel_err=1 on the output beat, operands bf_0_upper=bf_0_lower=q1. sel_err holds until start.
- Flush: issue rd_en, then start the next cycle (RD_LAT=2) → no bf_valid for the flushed beat. An rd_en issued with start appears as beat 0 of the new stage.
- Async reset mid-stream: pull rst low between clock edges during a burst → outputs go to 0 immediately. After release, there is no stale bf_valid and the counter restarts at 0.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared NTT datapath types: bank indices and default coefficient width.
// Imported by the read-side crossbar and its neighbours.
package ntt_pkg;

    typedef logic [1:0] bank_idx_t;

    localparam bank_idx_t BANK0 = 2'd0;
    localparam bank_idx_t BANK1 = 2'd1;
    localparam bank_idx_t BANK2 = 2'd2;
    localparam bank_idx_t BANK3 = 2'd3;

    localparam int NTT_DATA_WIDTH = 12;

endpackage

// File: rtl/sel_delay.sv
// Fixed-depth shift register with async active-low clear.
// Flush empties every stage past the input, which still loads din.
module sel_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= flush ? '0 : sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/butterfly_in.sv
// Read-side crossbar: routes bank read words to butterfly operands,
// with select alignment, beat counting and collision detection.
module butterfly_in
    import ntt_pkg::*;
#(
    parameter int data_width = NTT_DATA_WIDTH,
    parameter int RD_LAT     = 1,
    parameter int BF_CNT     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rd_en,
    input  logic [1:0]            sel_b_0,
    input  logic [1:0]            sel_b_1,
    input  logic [1:0]            sel_b_2,
    input  logic [1:0]            sel_b_3,
    input  logic [data_width-1:0] q0,
    input  logic [data_width-1:0] q1,
    input  logic [data_width-1:0] q2,
    input  logic [data_width-1:0] q3,
    output logic [data_width-1:0] bf_0_upper,
    output logic [data_width-1:0] bf_0_lower,
    output logic [data_width-1:0] bf_1_upper,
    output logic [data_width-1:0] bf_1_lower,
    output logic                  bf_valid,
    output logic                  bf_last,
    output logic                  sel_err
);

    localparam int CW = $clog2(BF_CNT);

    logic [8:0]            dly_in;
    logic [8:0]            dly_tap;
    logic                  tap_v;
    logic                  collide;
    bank_idx_t             tsel [4];
    logic [data_width-1:0] rt   [4];
    logic [CW-1:0]         cnt;

    assign dly_in = {rd_en, sel_b_0, sel_b_1, sel_b_2, sel_b_3};

    // start drops in-flight reads but still accepts this cycle's rd_en
    sel_delay #(
        .DEPTH (RD_LAT),
        .WIDTH (9)
    ) u_sel_delay (
        .clk   (clk),
        .rst   (rst),
        .flush (start),
        .din   (dly_in),
        .dout  (dly_tap)
    );

    assign tap_v   = dly_tap[8];
    assign tsel[0] = dly_tap[7:6];
    assign tsel[1] = dly_tap[5:4];
    assign tsel[2] = dly_tap[3:2];
    assign tsel[3] = dly_tap[1:0];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rt[i] = q0;
            unique case (tsel[i])
                BANK0: rt[i] = q0;
                BANK1: rt[i] = q1;
                BANK2: rt[i] = q2;
                BANK3: rt[i] = q3;
            endcase
        end
    end

    assign collide = (tsel[0] == tsel[1]) | (tsel[0] == tsel[2]) |
                     (tsel[0] == tsel[3]) | (tsel[1] == tsel[2]) |
                     (tsel[1] == tsel[3]) | (tsel[2] == tsel[3]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bf_0_upper <= '0;
            bf_0_lower <= '0;
            bf_1_upper <= '0;
            bf_1_lower <= '0;
            bf_valid   <= 1'b0;
            bf_last    <= 1'b0;
            sel_err    <= 1'b0;
            cnt        <= '0;
        end else if (start) begin
            bf_valid <= 1'b0;
            bf_last  <= 1'b0;
            sel_err  <= 1'b0;
            cnt      <= '0;
        end else if (tap_v) begin
            bf_0_upper <= rt[0];
            bf_0_lower <= rt[1];
            bf_1_upper <= rt[2];
            bf_1_lower <= rt[3];
            bf_valid   <= 1'b1;
            bf_last    <= (cnt == CW'(BF_CNT - 1));
            cnt        <= cnt + CW'(1);
            if (collide) begin
                sel_err <= 1'b1;
            end
        end else begin
            bf_valid <= 1'b0;
            bf_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_in.sv
// Directed bench for butterfly_in: routing table plus sequences for
// stage count, collision, flush and async reset.
module tb_butterfly_in;

    localparam int DW = 12;

    typedef struct {
        logic [1:0]    s [4];
        logic [DW-1:0] q [4];
        logic [DW-1:0] e [4];
        logic          err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          rd_en = 1'b0;
    logic [1:0]    s0 = '0, s1 = '0, s2 = '0, s3 = '0;
    logic [DW-1:0] q0 = '0, q1 = '0, q2 = '0, q3 = '0;
    logic [DW-1:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;

    logic [DW-1:0] a_u0, a_l0, a_u1, a_l1;
    logic          a_v, a_last, a_err;
    logic [DW-1:0] b_u0, b_l0, b_u1, b_l1;
    logic          b_v, b_last, b_err;

    int total = 0;
    int bad   = 0;

    vec_t vecs [6];

    always #5 clk = ~clk;

    butterfly_in #(.data_width(DW), .RD_LAT(1), .BF_CNT(64)) dut_a (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en),
        .sel_b_0(s0), .sel_b_1(s1), .sel_b_2(s2), .sel_b_3(s3),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .bf_0_upper(a_u0), .bf_0_lower(a_l0),
        .bf_1_upper(a_u1), .bf_1_lower(a_l1),
        .bf_valid(a_v), .bf_last(a_last), .sel_err(a_err)
    );

    butterfly_in #(.data_width(DW), .RD_LAT(2), .BF_CNT(64)) dut_b (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en),
        .sel_b_0(s0), .sel_b_1(s1), .sel_b_2(s2), .sel_b_3(s3),
        .q0(p0), .q1(p1), .q2(p2), .q3(p3),
        .bf_0_upper(b_u0), .bf_0_lower(b_l0),
        .bf_1_upper(b_u1), .bf_1_lower(b_l1),
        .bf_valid(b_v), .bf_last(b_last), .sel_err(b_err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        rd_en = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic set_sel(input logic [1:0] a, input logic [1:0] b,
                           input logic [1:0] c, input logic [1:0] d);
        s0 = a; s1 = b; s2 = c; s3 = d;
    endtask

    task automatic chk_a(input string nm, input logic v, input logic l,
                         input logic er, input logic [DW-1:0] e0,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                         input logic [DW-1:0] e3);
        chk({nm, ".valid"}, 32'(a_v), 32'(v));
        chk({nm, ".last"}, 32'(a_last), 32'(l));
        chk({nm, ".err"}, 32'(a_err), 32'(er));
        chk({nm, ".u0"}, 32'(a_u0), 32'(e0));
        chk({nm, ".l0"}, 32'(a_l0), 32'(e1));
        chk({nm, ".u1"}, 32'(a_u1), 32'(e2));
        chk({nm, ".l1"}, 32'(a_l1), 32'(e3));
    endtask

    task automatic chk_b(input string nm, input logic v, input logic l,
                         input logic er, input logic [DW-1:0] e0,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                         input logic [DW-1:0] e3);
        chk({nm, ".valid"}, 32'(b_v), 32'(v));
        chk({nm, ".last"}, 32'(b_last), 32'(l));
        chk({nm, ".err"}, 32'(b_err), 32'(er));
        chk({nm, ".u0"}, 32'(b_u0), 32'(e0));
        chk({nm, ".l0"}, 32'(b_l0), 32'(e1));
        chk({nm, ".u1"}, 32'(b_u1), 32'(e2));
        chk({nm, ".l1"}, 32'(b_l1), 32'(e3));
    endtask

    function automatic vec_t mk(
        input logic [1:0] a, input logic [1:0] b,
        input logic [1:0] c, input logic [1:0] d,
        input logic [DW-1:0] x0, input logic [DW-1:0] x1,
        input logic [DW-1:0] x2, input logic [DW-1:0] x3,
        input logic [DW-1:0] y0, input logic [DW-1:0] y1,
        input logic [DW-1:0] y2, input logic [DW-1:0] y3,
        input logic er);
        vec_t v;
        v.s[0] = a;  v.s[1] = b;  v.s[2] = c;  v.s[3] = d;
        v.q[0] = x0; v.q[1] = x1; v.q[2] = x2; v.q[3] = x3;
        v.e[0] = y0; v.e[1] = y1; v.e[2] = y2; v.e[3] = y3;
        v.err = er;
        return v;
    endfunction

    // 64 pipelined reads plus one extra; bf_last only on beat 64
    task automatic run_stage(input string nm, input bit do_start);
        logic [DW-1:0] d;
        if (do_start) pulse_start();
        set_sel(2'd0, 2'd1, 2'd2, 2'd3);
        for (int i = 0; i <= 65; i++) begin
            rd_en = (i < 65);
            if (i >= 1) begin
                d  = DW'(i - 1);
                q0 = d;
                q1 = d ^ 12'h800;
                q2 = d ^ 12'h400;
                q3 = d ^ 12'hC00;
            end
            tick();
            if (i >= 1) begin
                chk($sformatf("%s.v%0d", nm, i), 32'(a_v), 32'd1);
                chk($sformatf("%s.last%0d", nm, i), 32'(a_last),
                    32'((i - 1) == 63));
                chk($sformatf("%s.u0_%0d", nm, i), 32'(a_u0), 32'(i - 1));
                chk($sformatf("%s.l1_%0d", nm, i), 32'(a_l1),
                    32'(DW'(i - 1) ^ 12'hC00));
            end
        end
        rd_en = 1'b0;
    endtask

    initial begin
        vecs[0] = mk(0, 1, 2, 3, 10, 20, 30, 40, 10, 20, 30, 40, 0);
        vecs[1] = mk(3, 2, 1, 0, 12'h111, 12'h222, 12'h333, 12'hABC,
                     12'hABC, 12'h333, 12'h222, 12'h111, 0);
        vecs[2] = mk(2, 3, 0, 1, 5, 6, 7, 8, 7, 8, 5, 6, 0);
        vecs[3] = mk(1, 1, 2, 3, 12'h0A1, 12'h0B2, 12'h0C3, 12'h0D4,
                     12'h0B2, 12'h0B2, 12'h0C3, 12'h0D4, 1);
        vecs[4] = mk(3, 3, 3, 3, 1, 2, 3, 12'hFFF,
                     12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1);
        vecs[5] = mk(0, 2, 0, 2, 100, 200, 300, 400, 100, 300, 100, 300, 1);

        // reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            start = 1'($urandom);
            set_sel(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
            q0 = DW'($urandom); q1 = DW'($urandom);
            q2 = DW'($urandom); q3 = DW'($urandom);
            p0 = DW'($urandom); p1 = DW'($urandom);
            tick();
        end
        chk_a("rst_a", 0, 0, 0, 0, 0, 0, 0);
        chk_b("rst_b", 0, 0, 0, 0, 0, 0, 0);
        rd_en = 1'b0;
        start = 1'b0;
        #3 rst = 1'b1;
        tick();

        // routing table: one read, then an idle hold cycle
        for (int k = 0; k < 6; k++) begin
            pulse_start();
            rd_en = 1'b1;
            set_sel(vecs[k].s[0], vecs[k].s[1], vecs[k].s[2], vecs[k].s[3]);
            q0 = DW'($urandom); q1 = DW'($urandom);
            q2 = DW'($urandom); q3 = DW'($urandom);
            tick();
            rd_en = 1'b0;
            set_sel(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
            q0 = vecs[k].q[0]; q1 = vecs[k].q[1];
            q2 = vecs[k].q[2]; q3 = vecs[k].q[3];
            tick();
            chk_a($sformatf("vec%0d", k), 1, 0, vecs[k].err,
                  vecs[k].e[0], vecs[k].e[1], vecs[k].e[2], vecs[k].e[3]);
            q0 = ~q0; q1 = ~q1; q2 = ~q2; q3 = ~q3;
            tick();
            chk_a($sformatf("hold%0d", k), 0, 0, vecs[k].err,
                  vecs[k].e[0], vecs[k].e[1], vecs[k].e[2], vecs[k].e[3]);
        end

        // sticky collision survives a clean beat, cleared by start
        pulse_start();
        rd_en = 1'b1;
        set_sel(2'd1, 2'd1, 2'd2, 2'd3);
        tick();
        set_sel(2'd0, 2'd1, 2'd2, 2'd3);
        q0 = 12'h010; q1 = 12'h020; q2 = 12'h030; q3 = 12'h040;
        tick();
        chk_a("coll", 1, 0, 1, 12'h020, 12'h020, 12'h030, 12'h040);
        rd_en = 1'b0;
        q0 = 12'h501; q1 = 12'h502; q2 = 12'h503; q3 = 12'h504;
        tick();
        chk_a("coll_clean", 1, 0, 1, 12'h501, 12'h502, 12'h503, 12'h504);
        tick();
        chk_a("coll_idle", 0, 0, 1, 12'h501, 12'h502, 12'h503, 12'h504);
        pulse_start();
        chk_a("coll_clr", 0, 0, 0, 12'h501, 12'h502, 12'h503, 12'h504);

        run_stage("stage", 1'b1);
        tick();

        // async reset in the middle of a burst
        pulse_start();
        rd_en = 1'b1;
        set_sel(2'd0, 2'd1, 2'd2, 2'd3);
        for (int i = 0; i < 4; i++) begin
            q0 = 12'h0F0; q1 = 12'h0F1; q2 = 12'h0F2; q3 = 12'h0F3;
            tick();
        end
        chk("burst.valid", 32'(a_v), 32'd1);
        #3 rst = 1'b0;
        #1;
        chk_a("arst", 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rd_en = 1'b0;
        #3 rst = 1'b1;
        tick();
        chk_a("arst_rel1", 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_a("arst_rel2", 0, 0, 0, 0, 0, 0, 0);
        run_stage("restart", 1'b0);
        tick();

        // flush on the RD_LAT=2 instance
        pulse_start();
        tick();
        rd_en = 1'b1;
        set_sel(2'd0, 2'd1, 2'd2, 2'd3);
        tick();
        start = 1'b1;
        set_sel(2'd3, 2'd2, 2'd1, 2'd0);
        tick();
        chk("flush.v0", 32'(b_v), 32'd0);
        start = 1'b0;
        rd_en = 1'b0;
        p0 = 12'h0AA; p1 = 12'h0BB; p2 = 12'h0CC; p3 = 12'h0DD;
        tick();
        chk("flush.v1", 32'(b_v), 32'd0);
        p0 = 12'h001; p1 = 12'h002; p2 = 12'h003; p3 = 12'h004;
        tick();
        chk_b("flush_new", 1, 0, 0, 12'h004, 12'h003, 12'h002, 12'h001);
        tick();
        chk("flush.v3", 32'(b_v), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
